// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the spi_arb SPI monarch arbiter.
// The watchdog feature is enabled by defining SPI_ARB_TIMEOUT_EN.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          NUM_REQ_DEF   = 2;
    localparam int          TO_CYCLES_DEF = 4096;
    localparam logic [15:0] TO_RESP       = 16'h0000;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational rotate-priority picker: first set req searching upward from
// last+1 with wrap. gnt_idx is only meaningful while gnt_vld is high.
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic               gnt_vld,
    output logic [1:0]         gnt_idx
);

    assign gnt_vld = |req;

    // Walk from the farthest slot to the nearest so the nearest set request overwrites.
    always_comb begin
        gnt_idx = 2'd0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                gnt_idx = (req[i] && (i == ((int'(last) + k) % NUM_REQ))) ? 2'(i) : gnt_idx;
            end
        end
    end

endmodule

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one 16-bit SPI transaction engine among NUM_REQ
// requesters, with optional grant lock. SPI_ARB_TIMEOUT_EN adds a WAIT watchdog.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      lock,
    input  logic [16*NUM_REQ-1:0]   cmd_bus,
    output logic [NUM_REQ-1:0]      done,
    output logic [15:0]             resp,
    output logic                    err,
    output logic [1:0]              owner,
    output logic                    busy,
    output logic                    spi_wrt,
    output logic [15:0]             spi_cmd,
    input  logic                    spi_done,
    input  logic [15:0]             spi_resp
);

    state_t               state_r, state_nx;
    logic [1:0]           owner_r, owner_nx;
    logic [1:0]           last_r, last_nx;
    logic                 lock_q_r, lock_q_nx;
    logic [15:0]          spi_cmd_r, spi_cmd_nx;
    logic [15:0]          resp_r, resp_nx;
    logic                 err_r, err_nx;
    logic [NUM_REQ-1:0]   done_r, done_nx;
    logic                 spi_wrt_r, spi_wrt_nx;
    logic                 busy_r, busy_nx;
    logic                 pick_vld_s;
    logic [1:0]           pick_idx_s;
    logic                 req_own_s;
    logic                 lock_own_s;
    logic [15:0]          cmd_sel_s;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);
    logic [15:0]          to_cnt_r, to_cnt_nx;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (req),
        .last    (last_r),
        .gnt_vld (pick_vld_s),
        .gnt_idx (pick_idx_s)
    );

    // Per-owner views of req/lock and the command of the grant being chosen.
    always_comb begin
        req_own_s  = 1'b0;
        lock_own_s = 1'b0;
        cmd_sel_s  = 16'h0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_own_s  = req_own_s  | (req[i]  & (owner_r  == 2'(i)));
            lock_own_s = lock_own_s | (lock[i] & (owner_r  == 2'(i)));
            cmd_sel_s  = (owner_nx == 2'(i)) ? cmd_bus[16*i +: 16] : cmd_sel_s;
        end
    end

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_nx   = state_r;
        owner_nx   = owner_r;
        last_nx    = last_r;
        lock_q_nx  = lock_q_r;
        spi_cmd_nx = spi_cmd_r;
        resp_nx    = resp_r;
        err_nx     = 1'b0;
        done_nx    = '0;
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_nx  = to_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (pick_vld_s) begin
                    // A held lock only counts while its owner is still requesting.
                    owner_nx   = (lock_q_r && req_own_s) ? owner_r : pick_idx_s;
                    spi_cmd_nx = cmd_sel_s;
                    state_nx   = ISSUE;
                end else begin
                    state_nx = IDLE;
                end
            end
            ISSUE: begin
                state_nx = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                to_cnt_nx = 16'd0;
`endif
            end
            WAIT: begin
                if (spi_done) begin
                    resp_nx   = spi_resp;
                    lock_q_nx = lock_own_s;
                    state_nx  = DONE;
                end else begin
`ifdef SPI_ARB_TIMEOUT_EN
                    if (to_cnt_r == TO_LAST) begin
                        resp_nx   = TO_RESP;
                        err_nx    = 1'b1;
                        lock_q_nx = 1'b0;
                        state_nx  = DONE;
                    end else begin
                        to_cnt_nx = to_cnt_r + 16'd1;
                    end
`else
                    state_nx = WAIT;
`endif
                end
            end
            DONE: begin
                last_nx  = owner_r;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        for (int i = 0; i < NUM_REQ; i++) begin
            done_nx[i] = (state_nx == DONE) && (owner_r == 2'(i));
        end
        spi_wrt_nx = (state_nx == ISSUE);
        busy_nx    = (state_nx != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            owner_r   <= 2'd0;
            last_r    <= 2'(NUM_REQ - 1);
            lock_q_r  <= 1'b0;
            spi_cmd_r <= 16'h0000;
            resp_r    <= 16'h0000;
            err_r     <= 1'b0;
            done_r    <= '0;
            spi_wrt_r <= 1'b0;
            busy_r    <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt_r  <= 16'd0;
`endif
        end else begin
            state_r   <= state_nx;
            owner_r   <= owner_nx;
            last_r    <= last_nx;
            lock_q_r  <= lock_q_nx;
            spi_cmd_r <= spi_cmd_nx;
            resp_r    <= resp_nx;
            err_r     <= err_nx;
            done_r    <= done_nx;
            spi_wrt_r <= spi_wrt_nx;
            busy_r    <= busy_nx;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt_r  <= to_cnt_nx;
`endif
        end
    end

    assign done    = done_r;
    assign resp    = resp_r;
    assign err     = err_r;
    assign owner   = owner_r;
    assign busy    = busy_r;
    assign spi_wrt = spi_wrt_r;
    assign spi_cmd = spi_cmd_r;

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb (NUM_REQ=2): table vectors, hand-written
// corner sequences and random transactions checked against a grant model.
module tb_spi_arb;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_C = 16;
`else
    localparam int TO_C = 4096;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, lock, done, owner;
    logic [31:0] cmd_bus;
    logic [15:0] resp, spi_cmd, spi_resp;
    logic        err, busy, spi_wrt, spi_done;

    int total = 0;
    int bad   = 0;

    // Reference model: last grant, last owner, lock flag.
    int m_last = 1;
    int m_own  = 0;
    bit m_lq   = 1'b0;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  lock;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [15:0] rsp;
        int          own;
    } vec_t;
    vec_t tbl[12];

    spi_arb #(.NUM_REQ(2), .TO_CYCLES(TO_C)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .cmd_bus(cmd_bus),
        .done(done), .resp(resp), .err(err), .owner(owner), .busy(busy),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_resp(spi_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [1:0] r);
        if (m_lq && r[m_own]) return m_own;
        for (int k = 1; k <= 2; k++) begin
            int c;
            c = (m_last + k) % 2;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_done(input int own, input logic [1:0] lk);
        m_last = own;
        m_own  = own;
        m_lq   = lk[own];
    endtask

    // Wait for spi_wrt; check latency, grant, latched command. Then scramble cmd_bus.
    task automatic start_txn(input int exp_own, input int exp_lat, input logic [15:0] exp_cmd);
        int n;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (spi_wrt) break;
        end
        chk("grant_latency", n, exp_lat);
        chk("spi_cmd_issue", spi_cmd, exp_cmd);
        chk("owner_issue", owner, exp_own);
        chk("busy_issue", busy, 1);
        cmd_bus = {$urandom};
    endtask

    // Act as the SPI monarch: answer after dly WAIT cycles, check the completion.
    task automatic finish_txn(input int dly, input logic [15:0] rsp, input int exp_own,
                              input logic [15:0] exp_cmd);
        logic [1:0] exp_d;
        exp_d = 2'(1 << exp_own);
        @(negedge clk);
        chk("wrt_one_cycle", spi_wrt, 0);
        repeat (dly - 1) @(negedge clk);
        spi_done = 1'b1;
        spi_resp = rsp;
        @(negedge clk);
        spi_done = 1'b0;
        spi_resp = 16'($urandom);
        chk("done_onehot", done, exp_d);
        chk("resp", resp, rsp);
        chk("err_clear", err, 0);
        chk("spi_cmd_held", spi_cmd, exp_cmd);
        chk("owner_done", owner, exp_own);
    endtask

    initial begin
        int exp, seen;
        logic [15:0] ec, r;

        tbl[0]  = '{2'b01, 2'b00, 16'hA25C, 16'h0000, 16'h00F3, 0};
        tbl[1]  = '{2'b11, 2'b00, 16'h1111, 16'h2222, 16'h0101, 1};
        tbl[2]  = '{2'b11, 2'b00, 16'h1111, 16'h2222, 16'h0202, 0};
        tbl[3]  = '{2'b11, 2'b00, 16'h1111, 16'h2222, 16'h0303, 1};
        tbl[4]  = '{2'b11, 2'b00, 16'h1111, 16'h2222, 16'h0404, 0};
        tbl[5]  = '{2'b11, 2'b01, 16'h3333, 16'h4444, 16'h0505, 1};
        tbl[6]  = '{2'b11, 2'b01, 16'h3333, 16'h4444, 16'h0606, 0};
        tbl[7]  = '{2'b11, 2'b01, 16'h5555, 16'h6666, 16'h0707, 0};
        tbl[8]  = '{2'b11, 2'b00, 16'h7777, 16'h8888, 16'h0808, 0};
        tbl[9]  = '{2'b11, 2'b00, 16'h7777, 16'h8888, 16'h0909, 1};
        tbl[10] = '{2'b10, 2'b10, 16'h9999, 16'hAAAA, 16'h0A0A, 1};
        tbl[11] = '{2'b01, 2'b00, 16'hBBBB, 16'hCCCC, 16'h0B0B, 0};

        rst_n = 1'b0; req = 2'b00; lock = 2'b00; cmd_bus = 32'h0;
        spi_done = 1'b0; spi_resp = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_wrt", spi_wrt, 0);
        chk("rst_cmd", spi_cmd, 0);
        chk("rst_done", done, 0);
        chk("rst_resp", resp, 0);
        chk("rst_owner", owner, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: single request, contention rotation, lock hold and release.
        for (int i = 0; i < 12; i++) begin
            req = tbl[i].req; lock = tbl[i].lock; cmd_bus = {tbl[i].c1, tbl[i].c0};
            ec = (tbl[i].own == 1) ? tbl[i].c1 : tbl[i].c0;
            start_txn(tbl[i].own, (i == 0) ? 1 : 2, ec);
            finish_txn(1 + (i % 3), tbl[i].rsp, tbl[i].own, ec);
            model_done(tbl[i].own, tbl[i].lock);
        end

        // Requester 0 pulses req during requester 1's transaction; both then drop.
        req = 2'b10; lock = 2'b00; cmd_bus = {16'hC0DE, 16'hDEAD};
        exp = model_pick(req);
        start_txn(exp, 2, 16'hC0DE);
        req = 2'b11;
        @(negedge clk);
        req = 2'b00;
        finish_txn(2, 16'h1234, exp, 16'hC0DE);
        model_done(exp, lock);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done != 2'b00 || spi_wrt) seen++;
        end
        chk("withdrawn_no_grant", seen, 0);
        chk("withdrawn_idle", busy, 0);

        // Async reset in WAIT, then a stray spi_done.
        req = 2'b01; lock = 2'b01; cmd_bus = {16'h0000, 16'h5A5A};
        exp = model_pick(req);
        start_txn(exp, 1, 16'h5A5A);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd", spi_cmd, 0);
        chk("midrst_owner", owner, 0);
        @(negedge clk);
        rst_n = 1'b1; req = 2'b00; lock = 2'b00;
        m_last = 1; m_own = 0; m_lq = 1'b0;
        @(negedge clk);
        spi_done = 1'b1; spi_resp = 16'hBEEF;
        @(negedge clk);
        spi_done = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done != 2'b00 || busy) seen++;
        end
        chk("stray_done_ignored", seen, 0);
        chk("stray_resp", resp, 0);
        req = 2'b10; cmd_bus = {16'h6B6B, 16'h0000};
        exp = model_pick(req);
        start_txn(exp, 1, 16'h6B6B);
        finish_txn(1, 16'h7777, exp, 16'h6B6B);
        model_done(exp, lock);

        // Random traffic against the model.
        for (int t = 0; t < 40; t++) begin
            req = 2'($urandom_range(1, 3));
            lock = 2'($urandom_range(0, 3));
            cmd_bus = {$urandom};
            exp = model_pick(req);
            ec = (exp == 1) ? cmd_bus[31:16] : cmd_bus[15:0];
            r = 16'($urandom);
            start_txn(exp, 2, ec);
            finish_txn(int'($urandom_range(1, 4)), r, exp, ec);
            model_done(exp, lock);
        end

        // Silent SPI engine: watchdog completion, or indefinite wait without it.
        req = 2'b01; lock = 2'b01; cmd_bus = {16'h0000, 16'hF00D};
        exp = model_pick(req);
        start_txn(exp, 2, 16'hF00D);
`ifdef SPI_ARB_TIMEOUT_EN
        seen = 0;
        while (seen < 40) begin
            @(negedge clk);
            seen++;
            if (done != 2'b00) break;
        end
        chk("timeout_cycles", seen, TO_C + 1);
        chk("timeout_done", done, 2'(1 << exp));
        chk("timeout_err", err, 1);
        chk("timeout_resp", resp, 0);
        m_last = exp; m_own = exp; m_lq = 1'b0;
`else
        repeat (40) @(negedge clk);
        chk("wait_holds_busy", busy, 1);
        chk("wait_no_done", done, 0);
        chk("wait_no_err", err, 0);
        finish_txn(1, 16'h4242, exp, 16'hF00D);
        model_done(exp, lock);
`endif
        req = 2'b10; lock = 2'b00; cmd_bus = {16'h9A9A, 16'h0000};
        exp = model_pick(req);
        start_txn(exp, 2, 16'h9A9A);
        finish_txn(2, 16'h5151, exp, 16'h9A9A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
